// File: rtl/spm_gen.sv
// Serial shift-add multiplier: one multiplier bit per clock, LSB first, exact 2*WIDTH product.
// Define SPM_GEN_ACC_EN to enable accumulating the product into P when acc is latched high.
module spm_gen #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               acc,
  input  logic [WIDTH-1:0]   MP,
  input  logic [WIDTH-1:0]   MC,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | consuming one multiplier bit per cycle
  // DONE  | one-cycle result strobe; P just loaded, start accepted here

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] mp_sr;
  logic [PW-1:0]   mc_sh;
  logic [PW-1:0]   accum;
  logic [PW-1:0]   term;
  logic [PW-1:0]   accum_nxt;
  logic [PW-1:0]   p_nxt;
  logic [CW-1:0]   cnt;
  logic            sgn_l;
  logic            acc_l;
  logic            load;
  logic            last;

  assign load = start && (state == IDLE || state == DONE);
  assign last = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // MSB of a signed multiplier carries weight -2^(WIDTH-1), so the final step subtracts
  always_comb begin
    term      = mp_sr[0] ? mc_sh : '0;
    accum_nxt = (sgn_l && last) ? accum - term : accum + term;
  end

  // cnt counts remaining bits down; terminal count 0 is the multiplier MSB
  always_ff @(posedge clk) begin
    if (reset) begin
      mp_sr <= '0;
      mc_sh <= '0;
      accum <= '0;
      cnt   <= '0;
      sgn_l <= 1'b0;
      acc_l <= 1'b0;
    end else if (load) begin
      mp_sr <= MP;
      mc_sh <= signed_mode ? {{WIDTH{MC[WIDTH-1]}}, MC} : {{WIDTH{1'b0}}, MC};
      accum <= '0;
      cnt   <= CW'(WIDTH - 1);
      sgn_l <= signed_mode;
      acc_l <= acc;
    end else if (state == RUN) begin
      accum <= accum_nxt;
      mp_sr <= mp_sr >> 1;
      mc_sh <= mc_sh << 1;
      cnt   <= cnt - CW'(1);
    end
  end

`ifdef SPM_GEN_ACC_EN
  assign p_nxt = acc_l ? P + accum_nxt : accum_nxt;
`else
  logic unused_acc;
  assign unused_acc = acc_l;
  assign p_nxt      = accum_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset)                    P <= '0;
    else if (state == RUN && last) P <= p_nxt;
  end

endmodule

// File: tb/tb_spm_gen.sv
// Scoreboard bench for spm_gen: stimulus pushes expected results, a negedge monitor checks each done.
module tb_spm_gen;
  localparam int W = 32;
`ifdef SPM_GEN_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, start, signed_mode, acc;
  logic [W-1:0]   MP, MC;
  logic [2*W-1:0] P;
  logic           busy, done;

  spm_gen #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .acc(acc),
    .MP(MP), .MC(MC), .P(P), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] p; int cyc; } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0, n_err = 0, cyc = 0, busy_cnt = 0;
  logic [63:0] model_p = '0;
  logic [63:0] p_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb2;
    if (sgn) begin
      sa  = $signed(a);
      sb2 = $signed(b);
      return 64'(sa * sb2);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the start cycle is the current one.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic ac);
    exp_t        e;
    logic [63:0] pr;
    pr = ref_prod(a, b, sgn);
    if (ac && ACC) pr = model_p + pr;
    model_p = pr;
    e.p   = pr;
    e.cyc = cyc;
    sb.push_back(e);
    MP = a; MC = b; signed_mode = sgn; acc = ac; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    MP = $urandom; MC = $urandom; signed_mode = 1'($urandom); acc = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL done_timeout: got no done in 60 cycles, required done");
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done with P=%h, required no done", P);
      end else begin
        mon_e = sb.pop_front();
        check("product", P, mon_e.p);
        check("latency", 64'(cyc - mon_e.cyc), 64'd33);
        check("busy_cycles", 64'(busy_cnt), 64'd32);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
      check("p_hold", P, p_prev);
    end else begin
      busy_cnt = 0;
    end
    p_prev = P;
  end

  initial begin
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; acc = 1'b0; MP = '0; MC = '0;
    repeat (3) @(negedge clk);
    check("reset_p", P, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    start_op(32'd15, 32'hFFFF_FFF3, 1'b1, 1'b0); wait_done();
    check("signed_15x-13", P, 64'hFFFF_FFFF_FFFF_FF3D);
    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0); wait_done();
    check("umax_sq", P, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0); wait_done();
    check("smin_sq", P, 64'h4000_0000_0000_0000);
    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0); wait_done();

    // start during RUN must be ignored
    @(negedge clk);
    start_op(32'd7, 32'd9, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    MP = 32'd2; MC = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    check("ignored_start_p", P, 64'd63);
    repeat (40) @(negedge clk);
    check("single_done", 64'(sb.size()), 64'd0);

    // reset aborts an in-flight operation
    @(negedge clk);
    start_op(32'd123, 32'd456, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    model_p = '0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_p", P, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    start_op(32'd3, 32'd5, 1'b0, 1'b0); wait_done();
    check("after_abort", P, 64'd15);

    // back-to-back: second start issued in the DONE cycle
    @(negedge clk);
    start_op(32'd100, 32'hFFFF_FFFF, 1'b1, 1'b0); wait_done();
    check("b2b_first", P, 64'hFFFF_FFFF_FFFF_FF9C);
    start_op(32'd6, 32'd7, 1'b1, 1'b0); wait_done();
    check("b2b_second", P, 64'd42);

    @(negedge clk);
    start_op(32'd3, 32'd4, 1'b0, 1'b0); wait_done();
    start_op(32'd5, 32'd6, 1'b0, 1'b1); wait_done();
    check("acc_result", P, ACC ? 64'd42 : 64'd30);

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = 32'h8000_0000;
      if (i % 7 == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      start_op(a, b, 1'($urandom), 1'($urandom));
      wait_done();
    end

    repeat (40) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spm_gen.md
SPM_GEN -- requirements
Module: spm_gen

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  rising-edge clock; only clock in the block.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled on the rising edge of clk.
REQ-005 SHALL have port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port: acc  input  1  accumulate request; sampled with start (see REQ-024).
REQ-007 SHALL have port: MP  input  WIDTH  multiplier; consumed serially, LSB first.
REQ-008 SHALL have port: MC  input  WIDTH  multiplicand; parallel operand.
REQ-009 SHALL have port: P  output  2*WIDTH  registered product.
REQ-010 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; P valid.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE or DONE with start=1: latch MP, MC, signed_mode and acc; clear internal accumulator and bit counter; go to RUN. Otherwise DONE -> IDLE, IDLE -> IDLE.
REQ-014 RUN: process one multiplier bit per cycle, MP[cnt] for cnt = 0..WIDTH-1; when the bit is 1, add MC shifted left by cnt into the 2*WIDTH accumulator.
REQ-015 Signed mode: sign-extend MC to 2*WIDTH; for cnt = WIDTH-1, subtract instead of add (MSB weight is -2^(WIDTH-1)).
REQ-016 Unsigned mode: zero-extend MC; all bits add.
REQ-017 After processing cnt = WIDTH-1, go to DONE. In DONE, done=1 for exactly one cycle and P is loaded.
REQ-018 Latency: start high in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 and new P in cycle WIDTH+1.
REQ-019 busy=1 only in RUN.
REQ-020 start in RUN SHALL be ignored: no restart, operands unchanged.
REQ-021 start in the DONE cycle SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-022 P SHALL change only on entry to DONE or on reset; it holds its value during subsequent operations.
REQ-023 MP and MC may change after the start cycle without effect.
REQ-024 Result: P = MP*MC, exact in 2*WIDTH bits for both modes. This includes (-2^(WIDTH-1))^2 and (2^WIDTH-1)^2.

Reset
REQ-025 reset=1 on a clock edge SHALL force IDLE, P=0, busy=0, done=0, and clear the accumulator and counter.
REQ-026 reset SHALL abort any in-flight operation; no done is produced for it.
REQ-027 reset SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro SPM_GEN_ACC_EN SHALL control the accumulate feature.
REQ-029 With SPM_GEN_ACC_EN defined and acc latched as 1: in DONE, P = P_old + product, modulo 2^(2*WIDTH).
REQ-030 Without SPM_GEN_ACC_EN: the acc port SHALL be present but ignored; P = product always.

Verification (WIDTH=32)
REQ-031 Reset, then start with MP=15, MC=-13, signed_mode=1 -> done exactly 33 cycles after the start cycle; P=-195; busy high for 32 cycles.
REQ-032 Unsigned MP=MC=0xFFFFFFFF -> P=0xFFFFFFFE00000001; signed MP=MC=0x80000000 -> P=0x4000000000000000.
REQ-033 Start MP=7, MC=9, then pulse start with MP=2, MC=2 at cycle 10 -> ignored; P=63; single done pulse.
REQ-034 Start, then assert reset at cycle 5 -> P=0, busy=0, no done; a subsequent start with 3*5 -> P=15.
REQ-035 Start 100*-1 signed, then start 6*7 in its DONE cycle -> P=-100, then P=42 exactly 33 cycles later.
REQ-036 SPM_GEN_ACC_EN defined: 3*4 with acc=0, then 5*6 with acc=1 -> P=12, then P=42; macro undefined -> P=30.
REQ-037 20 random signed and unsigned pairs checked against the reference model P=MP*MC at each done -> zero mismatches.
